// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Latency: start bit on the line the cycle after the valid/ready handshake; each bit lasts CLKS_PER_BIT cycles.
// Backpressure: tx_ready is high only in IDLE; the source must hold tx_valid/tx_data until accepted.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst       synchronous active-high reset, dominates all other inputs
//   tx_data   byte to send, sampled only on the handshake
//   tx_valid  source has a byte
//   tx_ready  transmitter can accept a byte (combinational from state)
//   tx        registered serial line, idles high
//   tx_busy   high while any frame bit is on the line
//   tx_done   one-cycle pulse on the last cycle of the final stop bit
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit(s).

module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // Last cycle of a bit, and the cycle before it (tx_done is registered, so it
  // is set one cycle early to land on the final stop-bit cycle).
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DONE_CNT  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;   // data bit index in DATA, stop bit index in STOP
  logic [7:0]       shreg;
  logic             bit_end;

`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  assign bit_end  = (baud_cnt == LAST_CNT);
  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          tx       <= 1'b1;
          // tx_ready is implied by being in IDLE
          if (tx_valid) begin
            shreg      <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_data;
`endif
            state      <= START;
            tx         <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx      <= parity_bit;
`else
              state   <= STOP;
              tx      <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          tx <= 1'b1;
          if (bit_idx == LAST_STOP && baud_cnt == DONE_CNT) begin
            tx_done <= 1'b1;
          end
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx with a line-level reference model.
// Two instances at CLKS_PER_BIT=4: one with one stop bit, one with two stop bits.
// Inputs driven on the falling edge, outputs sampled on the falling edge.

module tb_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d1_data, d2_data;
  logic       d1_valid, d2_valid;
  logic       d1_ready, d1_tx, d1_busy, d1_done;
  logic       d2_ready, d2_tx, d2_busy, d2_done;

  logic       sel;
  logic       tx_s, ready_s, busy_s, done_s;

  int errors = 0;
  int checks = 0;

  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(d1_data), .tx_valid(d1_valid),
    .tx_ready(d1_ready), .tx(d1_tx), .tx_busy(d1_busy), .tx_done(d1_done)
  );

  uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_data(d2_data), .tx_valid(d2_valid),
    .tx_ready(d2_ready), .tx(d2_tx), .tx_busy(d2_busy), .tx_done(d2_done)
  );

  always_comb begin
    tx_s    = sel ? d2_tx    : d1_tx;
    ready_s = sel ? d2_ready : d1_ready;
    busy_s  = sel ? d2_busy  : d1_busy;
    done_s  = sel ? d2_done  : d1_done;
  end

  task automatic set_valid(input bit which, input logic v);
    if (which) d2_valid = v; else d1_valid = v;
  endtask

  task automatic set_data(input bit which, input logic [7:0] d);
    if (which) d2_data = d; else d1_data = d;
  endtask

  // Reference frame: one entry per bit time, built from the framing rules.
  task automatic build_exp(input bit which, input logic [7:0] b);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^b);
`endif
    for (int i = 0; i < (which ? 2 : 1); i++) exp_q.push_back(1'b1);
  endtask

  // Waits (bounded) for tx_ready, then presents the byte; acceptance happens on the next rising edge.
  task automatic start_byte(input bit which, input logic [7:0] b);
    int n;
    n = 0;
    sel = which;
    @(negedge clk);
    while (ready_s !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready_s !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: tx_ready=%b required 1", ready_s);
    end
    set_data(which, b);
    set_valid(which, 1'b1);
  endtask

  // Checks every cycle of one frame against the reference; also recovers the byte by mid-bit sampling.
  // On the first frame cycle either drops tx_valid or (keeping it high) swaps tx_data to nd.
  task automatic check_frame(input bit which, input logic [7:0] b, input bit drop,
                             input logic [7:0] nd, output logic [7:0] rx);
    int   n;
    logic exp_tx, exp_done;
    build_exp(which, b);
    n  = exp_q.size() * C;
    rx = 8'h00;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (drop) set_valid(which, 1'b0);
        else      set_data(which, nd);
      end
      exp_tx   = exp_q[k / C];
      exp_done = (k == n - 1);
      checks++;
      if (tx_s !== exp_tx) begin
        errors++;
        $display("FAIL frame_tx byte=%02h cycle=%0d: tx=%b required %b", b, k + 1, tx_s, exp_tx);
      end
      checks++;
      if (done_s !== exp_done) begin
        errors++;
        $display("FAIL frame_done byte=%02h cycle=%0d: tx_done=%b required %b", b, k + 1, done_s, exp_done);
      end
      checks++;
      if (busy_s !== 1'b1 || ready_s !== 1'b0) begin
        errors++;
        $display("FAIL frame_busy byte=%02h cycle=%0d: busy=%b ready=%b required 1 0", b, k + 1, busy_s, ready_s);
      end
      if ((k % C) == (C / 2) && (k / C) >= 1 && (k / C) <= 8) rx[(k / C) - 1] = tx_s;
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    checks++;
    if (tx_s !== 1'b1 || ready_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b0) begin
      errors++;
      $display("FAIL %s: tx=%b ready=%b busy=%b done=%b required 1 1 0 0", name, tx_s, ready_s, busy_s, done_s);
    end
  endtask

  task automatic check_rx(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: received %02h required %02h", name, got, want);
    end
  endtask

  task automatic send_checked(input bit which, input logic [7:0] b, input string name);
    logic [7:0] rx;
    start_byte(which, b);
    check_frame(which, b, 1'b1, b, rx);
    check_rx(name, rx, b);
    check_idle({name, "_idle"});
  endtask

  task automatic test_reset();
    bit bad;
    rst = 1'b1;
    d1_valid = 1'b0; d2_valid = 1'b0;
    d1_data = 8'h00; d2_data = 8'h00;
    sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (d1_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: tx=%b required 1", d1_tx); end
    checks++;
    if (d1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: tx_ready=%b required 1", d1_ready); end
    checks++;
    if (d1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: tx_busy=%b required 0", d1_busy); end
    checks++;
    if (d1_done !== 1'b0) begin errors++; $display("FAIL reset_done: tx_done=%b required 0", d1_done); end
    checks++;
    if (d2_tx !== 1'b1 || d2_ready !== 1'b1) begin
      errors++; $display("FAIL reset_dut2: tx=%b ready=%b required 1 1", d2_tx, d2_ready);
    end
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (d1_tx !== 1'b1 || d1_done !== 1'b0 || d1_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL idle_line: line left idle during 50 cycles, got bad=%b required 0", bad); end
  endtask

  task automatic test_single();
    send_checked(1'b0, 8'hA5, "single_a5");
  endtask

  task automatic test_parity();
    send_checked(1'b0, 8'h07, "parity_07");
    send_checked(1'b0, 8'h03, "parity_03");
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send_checked(1'b0, b, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx1, rx2;
    start_byte(1'b0, 8'h55);
    // tx_valid stays high through the whole first frame with a new byte behind it
    check_frame(1'b0, 8'h55, 1'b0, 8'hFF, rx1);
    check_idle("b2b_handshake");
    check_frame(1'b0, 8'hFF, 1'b1, 8'hFF, rx2);
    check_rx("b2b_first", rx1, 8'h55);
    check_rx("b2b_second", rx2, 8'hFF);
    check_idle("b2b_idle");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    bit bad;
    b = 8'($urandom);
    start_byte(1'b0, b);
    @(negedge clk);
    set_valid(1'b0, 1'b0);
    repeat (17) @(negedge clk);
    // frame cycle 18 sits inside data bit 3
    checks++;
    if (d1_tx !== b[3] || d1_busy !== 1'b1) begin
      errors++; $display("FAIL midframe_bit3: tx=%b busy=%b required %b 1", d1_tx, d1_busy, b[3]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (d1_tx !== 1'b1) begin errors++; $display("FAIL midframe_tx: tx=%b required 1", d1_tx); end
    checks++;
    if (d1_ready !== 1'b1 || d1_busy !== 1'b0) begin
      errors++; $display("FAIL midframe_ready: ready=%b busy=%b required 1 0", d1_ready, d1_busy);
    end
    rst = 1'b0;
    bad = (d1_done !== 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d1_done !== 1'b0 || d1_tx !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL midframe_no_done: stray activity bad=%b required 0", bad); end
    send_checked(1'b0, 8'h3C, "after_reset_3c");
  endtask

  task automatic test_two_stop_bits();
    send_checked(1'b1, 8'h00, "stop2_00");
    for (int i = 0; i < 3; i++) send_checked(1'b1, 8'($urandom), "stop2_random");
    sel = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    test_two_stop_bits();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
